// File: rtl/cbd_tc_pkg.sv
// Shared types and helpers for the terminal-count monitor (cbd_tc_monitor).
package cbd_tc_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_COUNT = 2'd1;
   localparam logic [1:0] ST_PEND  = 2'd2;
   localparam logic [1:0] ST_OVR   = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      COUNT = ST_COUNT,
      PEND  = ST_PEND,
      OVR   = ST_OVR
   } tc_state_t;

   // TERM must fit the term counter and be nonzero.
   function automatic bit tc_term_legal(input int evw, input int term);
      return (term >= 1) && (longint'(term) <= ((longint'(1) << evw) - 1));
   endfunction

endpackage

// File: rtl/cbd_tc_evcnt.sv
// Modulo counter with increment and synchronous clear; CD has priority over clr over inc.
module cbd_tc_evcnt #(
   parameter int W = 8
) (
   input  logic         CLK,
   input  logic         CD,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   localparam logic [W-1:0] ONE = W'(1);

   always_ff @(posedge CLK) begin
      if (CD || clr)
         cnt <= '0;
      else if (inc)
         cnt <= cnt + ONE;
   end

endmodule

// File: rtl/cbd_tc_monitor.sv
// Terminal-count monitor: counts underflow events, pulses TC/RELOAD, raises IRQ every TERM events.
// Optional `CBD_TC_SNAPSHOT_EN adds SNAP, which captures EVCNT whenever IRQ is (re)asserted.
module cbd_tc_monitor
   import cbd_tc_pkg::*;
#(
   parameter int EVW  = 8,
   parameter int TERM = 1
) (
   input  logic           CLK,
   input  logic           CD,
   input  logic           ARM,
   input  logic           CAO,
   input  logic           AUTORL,
   input  logic           ACK,
   output logic           TC,
   output logic           RELOAD,
   output logic [EVW-1:0] EVCNT,
   output logic           IRQ,
`ifdef CBD_TC_SNAPSHOT_EN
   output logic [EVW-1:0] SNAP,
`endif
   output logic           ORUN
);

   if (!tc_term_legal(EVW, TERM)) begin : g_bad_term
      $error("cbd_tc_monitor: TERM out of range 1..2**EVW-1");
   end

   localparam logic [EVW-1:0] TERM_LAST = EVW'(TERM - 1);
   localparam logic [EVW-1:0] ONE       = EVW'(1);

   tc_state_t      state;
   logic           ev;
   logic           boundary;
   logic [EVW-1:0] tcnt;

   // IDLE with ARM=1 enters COUNT on the same edge, so every armed CAO is an event.
   assign ev       = ARM && CAO;
   assign boundary = ev && (tcnt == TERM_LAST);

   cbd_tc_evcnt #(.W(EVW)) u_evcnt (
      .CLK (CLK),
      .CD  (CD),
      .clr (1'b0),
      .inc (ev),
      .cnt (EVCNT)
   );

   cbd_tc_evcnt #(.W(EVW)) u_tcnt (
      .CLK (CLK),
      .CD  (CD),
      .clr (boundary || !ARM),
      .inc (ev),
      .cnt (tcnt)
   );

   always_ff @(posedge CLK) begin
      if (CD) begin
         state  <= IDLE;
         TC     <= 1'b0;
         RELOAD <= 1'b0;
         IRQ    <= 1'b0;
         ORUN   <= 1'b0;
`ifdef CBD_TC_SNAPSHOT_EN
         SNAP   <= '0;
`endif
      end else if (!ARM) begin
         state  <= IDLE;
         TC     <= 1'b0;
         RELOAD <= 1'b0;
         IRQ    <= 1'b0;
         ORUN   <= 1'b0;
      end else begin
         TC     <= ev;
         RELOAD <= ev && AUTORL;
         case (state)
            IDLE, COUNT: begin
               if (boundary) begin
                  state <= PEND;
                  IRQ   <= 1'b1;
`ifdef CBD_TC_SNAPSHOT_EN
                  SNAP  <= EVCNT + ONE;
`endif
               end else begin
                  state <= COUNT;
               end
            end
            PEND: begin
               if (ACK && !boundary) begin
                  state <= COUNT;
                  IRQ   <= 1'b0;
               end else if (ACK && boundary) begin
                  // The fresh IRQ replaces the acknowledged one without a gap.
                  IRQ   <= 1'b1;
`ifdef CBD_TC_SNAPSHOT_EN
                  SNAP  <= EVCNT + ONE;
`endif
               end else if (boundary) begin
                  state <= OVR;
                  ORUN  <= 1'b1;
               end
            end
            OVR: begin
               if (ACK) begin
                  state <= COUNT;
                  IRQ   <= 1'b0;
                  ORUN  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
